// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern source.
package video_pkg;

  // Test pattern selector values, as driven on pattern_i.
  typedef enum logic [1:0] {
    BARS  = 2'd0,
    RAMP  = 2'd1,
    CHECK = 2'd2,
    FRAME = 2'd3
  } pattern_e;

  // Top-level run state.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } fsm_state_e;

  // One axis of raster timing: active, front porch, sync, back porch.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } timing_t;

  // Total positions on one axis.
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Colour-bar palette; index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_LUT = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster position counters with decoded sidebands.
// The counters hold the position of the next beat to be loaded; the
// decodes are combinational so the caller registers them with the pixel.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          vde_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          sof_o,
  output logic          last_o
);

  localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int HS_START = int'(H_T.active) + int'(H_T.fp);
  localparam int HS_END   = HS_START + int'(H_T.sync);
  localparam int VS_START = int'(V_T.active) + int'(V_T.fp);
  localparam int VS_END   = VS_START + int'(V_T.sync);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h32    = 32'(r_h);
  assign w_v32    = 32'(r_v);
  assign w_h_last = (w_h32 == H_TOTAL - 1);
  assign w_v_last = (w_v32 == V_TOTAL - 1);

  assign h_o    = r_h;
  assign v_o    = r_v;
  assign vde_o  = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
  assign hs_o   = (w_h32 >= HS_START) && (w_h32 < HS_END);
  assign vs_o   = (w_v32 >= VS_START) && (w_v32 < VS_END);
  assign sof_o  = (r_h == '0) && (r_v == '0);
  assign last_o = w_h_last && w_v_last;

  // Step one raster position per advance; v steps when h wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h <= '0;
      r_v <= '0;
    end else if (adv_i) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_src_gen.sv
// Programmable video timing and test-pattern source with valid/ready output.
// Every beat (active and blanking) is computed from the counter position,
// registered into the outputs, and held while the consumer stalls.
module video_src_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CHK_LOG2 = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] pattern_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       vde_o,
  output logic       sof_o,
  output logic       valid_o,
  input  logic       ready_i
);

  localparam int HW    = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW    = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int BAR_W = H_ACTIVE / 8;

  if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
    $error("video_src_gen: H_ACTIVE must be a multiple of 8");
  end

  fsm_state_e    r_state;
  pattern_e      r_pattern;
  logic [7:0]    r_frame_cnt;
  logic          r_last;

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_vde, w_hs, w_vs, w_sof, w_last;
  logic [31:0]   w_h32;
  logic [2:0]    w_bar;
  logic          w_chk_odd;
  logic [23:0]   w_ramp;
  logic [23:0]   w_rgb;
  pattern_e      w_pat;
  logic          w_last_acc;
  logic          w_done;
  logic          w_load;
  logic [7:0]    w_frame_next;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adv_i  (w_load),
    .h_o    (w_h),
    .v_o    (w_v),
    .vde_o  (w_vde),
    .hs_o   (w_hs),
    .vs_o   (w_vs),
    .sof_o  (w_sof),
    .last_o (w_last)
  );

  // Accepting the final beat of a frame; frame_cnt steps here, and the beat
  // loaded in the same cycle already belongs to the new frame.
  assign w_last_acc   = valid_o && ready_i && r_last;
  assign w_frame_next = r_frame_cnt + 8'(w_last_acc);
  assign w_done       = w_last_acc && ((r_state == S_FINISH) || ((r_state == S_RUN) && !en_i));

  // Load the next beat: on start from IDLE, on any free slot in RUN, and in
  // FINISH only until the last beat of the frame is on the output.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      S_IDLE:   w_load = en_i;
      S_RUN:    w_load = (!valid_o || ready_i) && !w_done;
      S_FINISH: w_load = valid_o && ready_i && !r_last;
      default:  w_load = 1'b0;
    endcase
  end

  assign w_h32     = 32'(w_h);
  assign w_bar     = 3'(w_h32 / BAR_W);
  assign w_chk_odd = w_h32[CHK_LOG2] ^ 1'(32'(w_v) >> CHK_LOG2);

  for (genvar gi = 0; gi < 3; gi++) begin : g_ramp
    assign w_ramp[gi*8 +: 8] = w_h32[7:0];
  end

  // Pattern mux; the selector is taken live only on the first beat of a frame.
  always_comb begin
    w_pat = w_sof ? pattern_e'(pattern_i) : r_pattern;
    w_rgb = 24'h000000;
    if (w_vde) begin
      case (w_pat)
        BARS:    w_rgb = BAR_LUT[w_bar];
        RAMP:    w_rgb = w_ramp;
        CHECK:   w_rgb = w_chk_odd ? 24'h000000 : 24'hFFFFFF;
        FRAME:   w_rgb = {w_frame_next, ~w_frame_next, 8'h80};
        default: w_rgb = 24'h000000;
      endcase
    end
  end

  // Run-state FSM with output register; outputs only change on a load or at frame end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pattern   <= BARS;
      r_frame_cnt <= 8'd0;
      r_last      <= 1'b0;
      valid_o     <= 1'b0;
      {r_o, g_o, b_o} <= 24'h000000;
      vde_o       <= 1'b0;
      sof_o       <= 1'b0;
      hsync_o     <= ~SYNC_POL;
      vsync_o     <= ~SYNC_POL;
    end else begin
      if (w_last_acc) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_load) begin
        valid_o <= 1'b1;
        {r_o, g_o, b_o} <= w_rgb;
        vde_o   <= w_vde;
        sof_o   <= w_sof;
        hsync_o <= w_hs ? SYNC_POL : ~SYNC_POL;
        vsync_o <= w_vs ? SYNC_POL : ~SYNC_POL;
        r_last  <= w_last;
        if (w_sof) begin
          r_pattern <= w_pat;
        end
      end else if (w_done) begin
        valid_o <= 1'b0;
        {r_o, g_o, b_o} <= 24'h000000;
        vde_o   <= 1'b0;
        sof_o   <= 1'b0;
        hsync_o <= ~SYNC_POL;
        vsync_o <= ~SYNC_POL;
        r_last  <= 1'b0;
      end
      case (r_state)
        S_IDLE:   if (en_i) r_state <= S_RUN;
        S_RUN:    if (!en_i) r_state <= w_done ? S_IDLE : S_FINISH;
        S_FINISH: if (w_done) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_src_gen.sv
// Directed bench for video_src_gen on a 14x7 raster (98 beats per frame).
module tb_video_src_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [1:0] pattern_i;
  logic [7:0] r_o, g_o, b_o;
  logic       hsync_o, vsync_o, vde_o, sof_o, valid_o;
  logic       ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_src_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CHK_LOG2(1)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .pattern_i (pattern_i),
    .r_o       (r_o),
    .g_o       (g_o),
    .b_o       (b_o),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .vde_o     (vde_o),
    .sof_o     (sof_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit act_pos(input int b);
    return ((b % 14) < 8) && ((b / 14) < 4);
  endfunction

  // Expected rgb for beat b of a frame, for patterns 0 (bars) and 2 (checker).
  function automatic logic [23:0] exp_rgb(input int b, input int pat);
    int h = b % 14;
    int v = b / 14;
    if (!act_pos(b)) return 24'h000000;
    if (pat == 0) return bars[h];
    return ((((h >> 1) ^ (v >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(negedge clk_i);
    cur = (cur + n) % 98;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, v, n;
    rst_i = 1'b1; en_i = 1'b0; ready_i = 1'b1; pattern_i = 2'd0;
    repeat (2) @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_rgb",   32'({r_o, g_o, b_o}), 32'd0);
    check("rst_vde",   32'(vde_o), 32'd0);
    check("rst_sof",   32'(sof_o), 32'd0);
    check("rst_hsync", 32'(hsync_o), 32'd1);
    check("rst_vsync", 32'(vsync_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_valid", 32'(valid_o), 32'd0);

    // 1: full first frame of colour bars with sync checks
    en_i = 1'b1;
    @(negedge clk_i);
    cur = 0;
    for (int b = 0; b < 98; b++) begin
      h = b % 14; v = b / 14;
      check($sformatf("f1_rgb_%0d", b),   32'({r_o, g_o, b_o}), 32'(exp_rgb(b, 0)));
      check($sformatf("f1_vde_%0d", b),   32'(vde_o), 32'(act_pos(b)));
      check($sformatf("f1_hs_%0d", b),    32'(hsync_o), 32'(!(h == 10 || h == 11)));
      check($sformatf("f1_vs_%0d", b),    32'(vsync_o), 32'(v != 5));
      check($sformatf("f1_sof_%0d", b),   32'(sof_o), 32'(b == 0));
      check($sformatf("f1_valid_%0d", b), 32'(valid_o), 32'd1);
      if (b == 1) check("f1_b1_hand", 32'({r_o, g_o, b_o}), 32'h00FFFF00);
      if (b == 8) check("f1_b8_hand", 32'({r_o, g_o, b_o, vde_o}), 32'd0);
      adv(1);
    end

    // 2: stall at h=3, v=0
    adv(3);
    ready_i = 1'b0;
    check("stall_rgb_0", 32'({r_o, g_o, b_o}), 32'h0000FF00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      check($sformatf("stall_rgb_%0d", i),   32'({r_o, g_o, b_o}), 32'h0000FF00);
      check($sformatf("stall_side_%0d", i),  32'({valid_o, vde_o, sof_o, hsync_o, vsync_o}), 32'b11011);
    end
    ready_i = 1'b1;
    adv(1);
    check("stall_next_rgb", 32'({r_o, g_o, b_o}), 32'h00FF00FF);
    check("stall_next_sof", 32'(sof_o), 32'd0);

    // 3: pattern change mid-frame at h=3, v=1
    adv(13);
    pattern_i = 2'd2;
    while (cur != 0) begin
      check($sformatf("pchg_rgb_%0d", cur), 32'({r_o, g_o, b_o}), 32'(exp_rgb(cur, 0)));
      adv(1);
    end
    check("chk_b0_sof", 32'(sof_o), 32'd1);
    check("chk_b0_rgb", 32'({r_o, g_o, b_o}), 32'h00FFFFFF);
    adv(2);
    check("chk_b2_rgb", 32'({r_o, g_o, b_o}), 32'h00000000);
    check("chk_b2_vde", 32'(vde_o), 32'd1);

    // 4: en_i drops at beat 40; remainder of frame still emitted
    adv(38);
    en_i = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && valid_o; i++) begin
      n++;
      if (n == 10) en_i = 1'b1;
      @(negedge clk_i);
    end
    check("fin_beats", 32'(n), 32'd58);
    check("fin_valid_low", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    cur = 0;
    check("restart_valid", 32'(valid_o), 32'd1);
    check("restart_sof", 32'(sof_o), 32'd1);
    check("restart_rgb", 32'({r_o, g_o, b_o}), 32'h00FFFFFF);

    // 5: reset during a stall
    ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mrst_valid", 32'(valid_o), 32'd0);
    check("mrst_sync",  32'({hsync_o, vsync_o}), 32'b11);
    check("mrst_rgb",   32'({r_o, g_o, b_o}), 32'd0);
    check("mrst_flags", 32'({vde_o, sof_o}), 32'd0);
    rst_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("mrst_restart_sof", 32'({valid_o, sof_o}), 32'b11);
    check("mrst_restart_rgb", 32'({r_o, g_o, b_o}), 32'h00FFFFFF);

    // 6: frame-colour pattern over three frames from reset
    pattern_i = 2'd3;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    cur = 0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 98; b++) begin
        if (f == 0 && b == 0) check("fc_f1_b0", 32'({r_o, g_o, b_o}), 32'h0000FF80);
        if (f == 1 && b == 0) check("fc_f2_b0", 32'({r_o, g_o, b_o}), 32'h0001FE80);
        if (f == 2) check($sformatf("fc_f3_%0d", b), 32'({r_o, g_o, b_o}),
                          act_pos(b) ? 32'h0002FD80 : 32'h0);
        adv(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
